// File: rtl/rename_dispatch_ctrl_pkg.sv
// Shared constants and types for the two-wide rename/dispatch controller.
package rename_dispatch_ctrl_pkg;

  localparam int unsigned REG_SEL = 5;
  localparam int unsigned RRF_SEL = 6;
  localparam int unsigned RRF_NUM = 64;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SPLIT = 1'b1
  } dispatch_state_e;

  // Slot-2 fields held across a split issue.
  typedef struct packed {
    logic               dst_en;
    logic [REG_SEL-1:0] dst_num;
  } slot2_hold_t;

endpackage

// File: rtl/rename_dispatch_ctrl_rrf_ptr_counter.sv
// RRF allocation pointer, free-entry count and wrap parity.
module rrf_ptr_counter #(
  parameter int unsigned PTR_W = 6,
  parameter int unsigned NUM   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alloc_num_i,
  input  logic [1:0]       com_num_i,
  output logic [PTR_W-1:0] rrfptr_o,
  output logic [PTR_W:0]   freenum_o,
  output logic             nextrrfcyc_o
);

  logic [PTR_W:0]   ptr_sum;
  logic [PTR_W:0]   ptr_wrapped;
  logic             ptr_wrap;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W+1:0] free_sum;
  logic [PTR_W:0]   free_d;

  always_comb begin
    ptr_sum     = {1'b0, rrfptr_o} + (PTR_W+1)'(alloc_num_i);
    ptr_wrap    = ptr_sum >= (PTR_W+1)'(NUM);
    ptr_wrapped = ptr_sum - (PTR_W+1)'(NUM);
    ptr_d       = ptr_wrap ? ptr_wrapped[PTR_W-1:0] : ptr_sum[PTR_W-1:0];
  end

  // Allocation and commit may land on the same edge; clamp at the table size.
  always_comb begin
    free_sum = {1'b0, freenum_o} - (PTR_W+2)'(alloc_num_i) + (PTR_W+2)'(com_num_i);
    free_d   = (free_sum > (PTR_W+2)'(NUM)) ? (PTR_W+1)'(NUM) : free_sum[PTR_W:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrfptr_o     <= '0;
      freenum_o    <= (PTR_W+1)'(NUM);
      nextrrfcyc_o <= 1'b0;
    end else begin
      rrfptr_o  <= ptr_d;
      freenum_o <= free_d;
      if (ptr_wrap) nextrrfcyc_o <= ~nextrrfcyc_o;
    end
  end

endmodule

// File: rtl/rename_dispatch_ctrl.sv
// Two-wide rename/dispatch sequencer: RRF tag allocation, ARF set-busy, intra-pair RAW handling.
// Optional macro RENAME_BYPASS_EN: dependent pairs issue in one cycle with dep flags instead of splitting.
module rename_dispatch_ctrl
  import rename_dispatch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               dec_valid_i,
  output logic               dec_ready_o,
  input  logic               inst1_dst_en_i,
  input  logic               inst2_dst_en_i,
  input  logic [REG_SEL-1:0] inst1_dst_num_i,
  input  logic [REG_SEL-1:0] inst2_dst_num_i,
  input  logic               inst2_valid_i,
  input  logic [REG_SEL-1:0] inst2_rs1_i,
  input  logic [REG_SEL-1:0] inst2_rs2_i,
  input  logic [1:0]         com_inst_num_i,
  output logic               setbusy1_en_o,
  output logic               setbusy2_en_o,
  output logic [REG_SEL-1:0] setbusy1_num_o,
  output logic [REG_SEL-1:0] setbusy2_num_o,
  output logic [RRF_SEL-1:0] rrftag1_o,
  output logic [RRF_SEL-1:0] rrftag2_o,
  output logic               alloc1_en_o,
  output logic               alloc2_en_o,
  output logic               inst2_rs1_dep_o,
  output logic               inst2_rs2_dep_o,
  output logic [RRF_SEL-1:0] rrfptr_o,
  output logic [RRF_SEL:0]   freenum_o,
  output logic               nextrrfcyc_o
);

`ifdef RENAME_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  dispatch_state_e state_q, state_d;
  slot2_hold_t     hold_q, hold_d;

  logic               eff1, eff2, waw;
  logic               dep_rs1, dep_rs2, dep_any;
  logic               accept;
  logic [RRF_SEL-1:0] ptr_plus1;
  logic [1:0]         alloc_num;

  // x0 is never renamed; slot 2 only counts when present.
  assign eff1      = inst1_dst_en_i && (inst1_dst_num_i != '0);
  assign eff2      = inst2_valid_i && inst2_dst_en_i && (inst2_dst_num_i != '0);
  assign waw       = eff1 && eff2 && (inst1_dst_num_i == inst2_dst_num_i);
  assign dep_rs1   = eff1 && inst2_valid_i && (inst2_rs1_i == inst1_dst_num_i);
  assign dep_rs2   = eff1 && inst2_valid_i && (inst2_rs2_i == inst1_dst_num_i);
  assign dep_any   = dep_rs1 || dep_rs2;
  assign ptr_plus1 = rrfptr_o + RRF_SEL'(1);

  assign dec_ready_o = (state_q == ST_RUN) && (freenum_o >= (RRF_SEL+1)'(2));
  assign accept      = dec_valid_i && dec_ready_o;
  assign alloc_num   = {1'b0, alloc1_en_o} + {1'b0, alloc2_en_o};

  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    setbusy1_en_o   = 1'b0;
    setbusy2_en_o   = 1'b0;
    setbusy1_num_o  = inst1_dst_num_i;
    setbusy2_num_o  = inst2_dst_num_i;
    rrftag1_o       = rrfptr_o;
    rrftag2_o       = rrfptr_o;
    alloc1_en_o     = 1'b0;
    alloc2_en_o     = 1'b0;
    inst2_rs1_dep_o = 1'b0;
    inst2_rs2_dep_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (dep_any && !BypassEn) begin
            alloc1_en_o   = 1'b1;
            setbusy1_en_o = 1'b1;
            hold_d        = '{dst_en: eff2, dst_num: inst2_dst_num_i};
            state_d       = ST_SPLIT;
          end else begin
            alloc1_en_o     = eff1;
            alloc2_en_o     = eff2;
            setbusy1_en_o   = eff1 && !waw;
            setbusy2_en_o   = eff2;
            rrftag2_o       = eff1 ? ptr_plus1 : rrfptr_o;
            inst2_rs1_dep_o = BypassEn && dep_rs1;
            inst2_rs2_dep_o = BypassEn && dep_rs2;
          end
        end
      end
      ST_SPLIT: begin
        // Held slot 2 is the only allocation this cycle, so it takes rrfptr.
        alloc2_en_o    = hold_q.dst_en;
        setbusy2_en_o  = hold_q.dst_en;
        setbusy2_num_o = hold_q.dst_num;
        hold_d         = '0;
        state_d        = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  rrf_ptr_counter #(
    .PTR_W (RRF_SEL),
    .NUM   (RRF_NUM)
  ) u_rrf_ptr_counter (
    .clk          (clk),
    .reset        (reset),
    .alloc_num_i  (alloc_num),
    .com_num_i    (com_inst_num_i),
    .rrfptr_o     (rrfptr_o),
    .freenum_o    (freenum_o),
    .nextrrfcyc_o (nextrrfcyc_o)
  );

endmodule

// File: tb/tb_rename_dispatch_ctrl.sv
// Randomized + directed bench for rename_dispatch_ctrl against a slot-list reference model.
module tb_rename_dispatch_ctrl;

`ifdef RENAME_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dec_valid_i = 1'b0;
  logic       dec_ready_o;
  logic       inst1_dst_en_i = 1'b0, inst2_dst_en_i = 1'b0;
  logic [4:0] inst1_dst_num_i = '0, inst2_dst_num_i = '0;
  logic       inst2_valid_i = 1'b0;
  logic [4:0] inst2_rs1_i = '0, inst2_rs2_i = '0;
  logic [1:0] com_inst_num_i = '0;
  logic       setbusy1_en_o, setbusy2_en_o;
  logic [4:0] setbusy1_num_o, setbusy2_num_o;
  logic [5:0] rrftag1_o, rrftag2_o;
  logic       alloc1_en_o, alloc2_en_o;
  logic       inst2_rs1_dep_o, inst2_rs2_dep_o;
  logic [5:0] rrfptr_o;
  logic [6:0] freenum_o;
  logic       nextrrfcyc_o;

  always #5 clk = ~clk;

  rename_dispatch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .dec_valid_i     (dec_valid_i),
    .dec_ready_o     (dec_ready_o),
    .inst1_dst_en_i  (inst1_dst_en_i),
    .inst2_dst_en_i  (inst2_dst_en_i),
    .inst1_dst_num_i (inst1_dst_num_i),
    .inst2_dst_num_i (inst2_dst_num_i),
    .inst2_valid_i   (inst2_valid_i),
    .inst2_rs1_i     (inst2_rs1_i),
    .inst2_rs2_i     (inst2_rs2_i),
    .com_inst_num_i  (com_inst_num_i),
    .setbusy1_en_o   (setbusy1_en_o),
    .setbusy2_en_o   (setbusy2_en_o),
    .setbusy1_num_o  (setbusy1_num_o),
    .setbusy2_num_o  (setbusy2_num_o),
    .rrftag1_o       (rrftag1_o),
    .rrftag2_o       (rrftag2_o),
    .alloc1_en_o     (alloc1_en_o),
    .alloc2_en_o     (alloc2_en_o),
    .inst2_rs1_dep_o (inst2_rs1_dep_o),
    .inst2_rs2_dep_o (inst2_rs2_dep_o),
    .rrfptr_o        (rrfptr_o),
    .freenum_o       (freenum_o),
    .nextrrfcyc_o    (nextrrfcyc_o)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state: plain integers, not the RTL encoding.
  int unsigned m_ptr, m_free;
  bit          m_cyc, m_split, m_hold_en;
  logic [4:0]  m_hold_dst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_init();
    m_ptr = 0; m_free = 64; m_cyc = 0; m_split = 0; m_hold_en = 0; m_hold_dst = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    dec_valid_i = 1'b0; com_inst_num_i = '0;
    reset = 1'b0;
    #2;
    check("rst_ptr", rrfptr_o, 0);
    check("rst_free", freenum_o, 64);
    check("rst_cyc", nextrrfcyc_o, 0);
    check("rst_ready", dec_ready_o, 1);
    check("rst_en", {alloc1_en_o, alloc2_en_o, setbusy1_en_o, setbusy2_en_o,
                     inst2_rs1_dep_o, inst2_rs2_dep_o}, 0);
    @(negedge clk);
    reset = 1'b1;
    model_init();
  endtask

  // One cycle: drive inputs, predict from the slot rules, compare, advance model.
  task automatic step(input bit v, input bit de1, input logic [4:0] d1,
                      input bit v2, input bit de2, input logic [4:0] d2,
                      input logic [4:0] r1, input logic [4:0] r2, input int unsigned com_req);
    bit e1, e2, dep1, dep2, rdy, nsplit;
    bit x_a1, x_a2, x_sb1, x_sb2, x_dp1, x_dp2;
    logic [4:0] x_n2;
    int unsigned x_t1, x_t2, n, k, com;
    @(negedge clk);
    dec_valid_i = v; inst1_dst_en_i = de1; inst1_dst_num_i = d1;
    inst2_valid_i = v2; inst2_dst_en_i = de2; inst2_dst_num_i = d2;
    inst2_rs1_i = r1; inst2_rs2_i = r2;
    {x_a1, x_a2, x_sb1, x_sb2, x_dp1, x_dp2} = '0;
    x_t1 = 0; x_t2 = 0; x_n2 = d2; n = 0; nsplit = 0;
    rdy = !m_split && m_free >= 2;
    e1 = de1 && d1 != 0;
    e2 = v2 && de2 && d2 != 0;
    if (m_split) begin
      x_a2 = m_hold_en; x_sb2 = m_hold_en; x_n2 = m_hold_dst; x_t2 = m_ptr;
      n = m_hold_en ? 1 : 0;
    end else if (v && rdy) begin
      dep1 = e1 && v2 && r1 == d1;
      dep2 = e1 && v2 && r2 == d1;
      if ((dep1 || dep2) && !BYP) begin
        x_a1 = 1; x_sb1 = 1; x_t1 = m_ptr; n = 1;
        nsplit = 1; m_hold_en = e2; m_hold_dst = d2;
      end else begin
        k = 0;
        if (e1) begin x_a1 = 1; x_sb1 = !(e2 && d1 == d2); x_t1 = (m_ptr + k) % 64; k++; end
        if (e2) begin x_a2 = 1; x_sb2 = 1; x_t2 = (m_ptr + k) % 64; k++; end
        n = k;
        x_dp1 = BYP && dep1; x_dp2 = BYP && dep2;
      end
    end
    com = com_req;
    if (m_free - n + com > 64) com = 64 - (m_free - n);
    assert (com <= 2 && m_free - n + com <= 64) else $error("commit overflow in stimulus");
    com_inst_num_i = com[1:0];
    #2;
    check("ready", dec_ready_o, rdy);
    check("ptr", rrfptr_o, m_ptr);
    check("free", freenum_o, m_free);
    check("cyc", nextrrfcyc_o, m_cyc);
    check("alloc1", alloc1_en_o, x_a1);
    check("alloc2", alloc2_en_o, x_a2);
    check("sb1", setbusy1_en_o, x_sb1);
    check("sb2", setbusy2_en_o, x_sb2);
    check("dep1", inst2_rs1_dep_o, x_dp1);
    check("dep2", inst2_rs2_dep_o, x_dp2);
    if (x_a1) check("tag1", rrftag1_o, x_t1);
    if (x_a2) check("tag2", rrftag2_o, x_t2);
    if (x_sb1) check("sb1_num", setbusy1_num_o, d1);
    if (x_sb2) check("sb2_num", setbusy2_num_o, x_n2);
    if (m_ptr + n >= 64) m_cyc = !m_cyc;
    m_ptr   = (m_ptr + n) % 64;
    m_free  = m_free - n + com;
    m_split = nsplit;
  endtask

  initial begin
    model_init();
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);                  // idle
    step(1, 1, 5'd1, 1, 1, 5'd2, 5'd7, 5'd8, 0);      // pair x1,x2 tags 0,1
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);                  // ptr 2, free 62
    for (int i = 0; i < 80 && m_ptr != 63; i++) step(1, 1, 5'd4, 0, 0, 0, 0, 0, 1);
    step(1, 1, 5'd9, 1, 1, 5'd10, 5'd1, 5'd2, 2);     // tags 63,0 wrap
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5'd3, 1, 1, 5'd3, 5'd1, 5'd2, 0);      // WAW x3
    step(1, 1, 5'd0, 1, 1, 5'd6, 5'd1, 5'd2, 0);      // inst1 dst x0
    step(1, 1, 5'd5, 1, 1, 5'd6, 5'd5, 5'd2, 0);      // RAW on rs1
    step(1, 1, 5'd7, 1, 1, 5'd8, 5'd1, 5'd2, 0);      // issues the held slot if split
    step(1, 1, 5'd7, 1, 1, 5'd8, 5'd9, 5'd7, 0);      // RAW on rs2
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    if (m_free % 2 == 0) step(1, 1, 5'd4, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 80 && m_free > 1; i++) step(1, 1, 5'd11, 1, 1, 5'd12, 5'd1, 5'd2, 0);
    step(1, 1, 5'd11, 1, 1, 5'd12, 5'd1, 5'd2, 1);    // free 1 -> not ready, commit 1
    step(1, 1, 5'd13, 1, 1, 5'd14, 5'd1, 5'd2, 2);    // ready again
    step(1, 1, 5'd5, 1, 1, 5'd6, 5'd5, 5'd5, 2);      // dependent pair, then reset mid-split
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5'd2, 1, 1, 5'd3, 5'd4, 5'd4, 0);
    for (int i = 0; i < 3000; i++) begin
      bit lowcom;
      int unsigned c;
      lowcom = ((i / 400) % 2) == 1;
      c = lowcom ? (($urandom_range(0, 3) == 0) ? 1 : 0) : $urandom_range(0, 2);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)),
           $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), c);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rename_dispatch_ctrl.md
Name: rename_dispatch_ctrl

Overview:
Two-wide rename/dispatch sequencer for the ARF/RRF rename datapath. It accepts a decoded instruction pair from the decoder, allocates RRF tags from a circular RRF pointer, and drives the ARF set-busy ports and RRF allocate-enables. It tracks free RRF entries against commits from the ROB and splits or bypasses intra-pair RAW dependencies.

Parameters:
REG_SEL, 5, architectural register index width
RRF_SEL, 6, RRF tag width
RRF_NUM, 64, RRF entries (= 2**RRF_SEL)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset (asserted at 0)
dec_valid_i  in  1  decoder pair valid
dec_ready_o  out  1  controller can accept a pair
inst1_dst_en_i / inst2_dst_en_i  in  1 each  slot writes a destination
inst1_dst_num_i / inst2_dst_num_i  in  REG_SEL each  destination register
inst2_valid_i  in  1  slot 2 present
inst2_rs1_i / inst2_rs2_i  in  REG_SEL each  slot 2 sources
com_inst_num_i  in  2  RRF entries retired this cycle (0..2)
setbusy1_en_o / setbusy2_en_o  out  1 each  ARF set-busy enable
setbusy1_num_o / setbusy2_num_o  out  REG_SEL each  ARF register to mark busy
rrftag1_o / rrftag2_o  out  RRF_SEL each  allocated tag, to ARF and RRF
alloc1_en_o / alloc2_en_o  out  1 each  RRF allocate enable
inst2_rs1_dep_o / inst2_rs2_dep_o  out  1 each  slot 2 source uses rrftag1_o
rrfptr_o  out  RRF_SEL  next tag to allocate
freenum_o  out  RRF_SEL+1  free RRF entries
nextrrfcyc_o  out  1  wrap parity, toggles on each rrfptr wrap

Behaviour:
- Reset: rrfptr_o=0, freenum_o=RRF_NUM, nextrrfcyc_o=0, state RUN, holding register cleared. All enables and dep outputs are 0.
- Effective dst: dst_en && dst_num!=0. Register x0 is never renamed. Slot 2 counts only if inst2_valid_i.
- dec_ready_o = (state==RUN) && freenum_o>=2. The output is registered-state only and never depends on dec_valid_i.
- Accept = dec_valid_i && dec_ready_o. Slot outputs are combinational in the accept cycle (0 latency). The ARF and RRF capture them at the same edge.
- Tag assignment: the first effective slot gets rrfptr, the second gets rrfptr+1 mod RRF_NUM. alloc*_en = effective dst. Tags are don't-care when the enable is 0.
- WAW within the pair (both effective, equal dst_num): setbusy1_en_o is suppressed. Both RRF allocations still occur.
- Dependency: inst2 rs1/rs2 == inst1 effective dst_num.
- States: RUN, SPLIT.
  - RUN, accept, no dep (or bypass build): issue both slots and stay in RUN.
  - RUN, accept, dep (no bypass build): issue slot 1 only, latch slot 2 fields, go to SPLIT.
  - SPLIT: dec_ready_o=0. Slot 2 issues from the holding register; slot 1 outputs are 0. Always return to RUN next edge.
- Counters at each edge: n = number of allocations this cycle.
  - rrfptr += n, mod RRF_NUM. nextrrfcyc toggles if the add crosses RRF_NUM-1→0.
  - freenum = freenum − n + com_inst_num_i, with simultaneous alloc and commit allowed.
  - freenum saturates at RRF_NUM. Overflow is a protocol error and is covered by a bench assertion.
- SPLIT is guaranteed ≥1 free entry because accept required ≥2.
- Reset mid-SPLIT discards the held slot 2.

Optional Feature:
RENAME_BYPASS_EN
- Defined: dependent pairs issue in one cycle. inst2_rs*_dep_o=1 for each matching source, and downstream takes the source tag from rrftag1_o. SPLIT state is unreachable.
- Undefined: dep outputs are tied 0 and dependent pairs use SPLIT (2 cycles).

Decomposition:
- REG_SEL, RRF_SEL, RRF_NUM and the state encoding go in the shared Consts.v defines.
- One sub-module, rrf_ptr_counter, holds rrfptr, freenum and nextrrfcyc. Its inputs are the alloc count and the commit count.
- The dependency check and FSM stay in the top module.

Test Plan:
- Reset then idle → rrfptr_o=0, freenum_o=64, dec_ready_o=1, all enables 0.
- Pair dst x1, x2, no dep, rrfptr=0 → rrftag1_o=0, rrftag2_o=1, both setbusy asserted; next cycle rrfptr_o=2, freenum_o=62.
- rrfptr=63, pair with two dsts → tags 63 and 0; next cycle rrfptr_o=1, nextrrfcyc_o toggles.
- freenum=1 → dec_ready_o=0. com_inst_num_i=1 that cycle → next cycle freenum_o=2, dec_ready_o=1.
- inst1 dst x5, inst2 rs1=x5 (no bypass) → cycle 0 only slot 1 with tag 12; cycle 1 slot 2 with tag 13, dec_ready_o=0; cycle 2 back in RUN. With RENAME_BYPASS_EN → single cycle, inst2_rs1_dep_o=1.
- Both dst=x3 → setbusy1_en_o=0, setbusy2_en_o=1, alloc1/alloc2 both 1. Second case: inst1 dst=x0 → alloc1_en_o=0, slot 2 gets rrfptr.
